param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost-full threshold (1..DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 2, almost-empty threshold (1..DEPTH-1).
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst_  input  1  reset, synchronous, active-low.
REQ-007 fifo_write  input  1  write request.
REQ-008 fifo_read  input  1  read request.
REQ-009 fifo_data_in  input  WIDTH  write data.
REQ-010 fifo_data_out  output  WIDTH  read data, registered.
REQ-011 fifo_full, fifo_empty  output  1 each  occupancy flags.
REQ-012 fifo_almost_full, fifo_almost_empty  output  1 each  threshold flags.
REQ-013 fifo_cnt  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 fifo_overflow, fifo_underflow  output  1 each  sticky error flags (see Configuration).

Function
REQ-015 Internal registers SHALL be named rd_ptr, wr_ptr ($clog2(DEPTH) bits each) and cnt; the bench probes them hierarchically.
REQ-016 Write accepted when fifo_write && (!fifo_full || fifo_read); accepted write stores fifo_data_in at wr_ptr, wr_ptr increments.
REQ-017 Read accepted when fifo_read && !fifo_empty; accepted read loads mem[rd_ptr] into fifo_data_out next edge, rd_ptr increments (1-cycle latency).
REQ-018 Read on empty SHALL not move rd_ptr and SHALL hold fifo_data_out, even with simultaneous write.
REQ-019 Write on full without read SHALL not move wr_ptr nor alter memory.
REQ-020 Write and read both accepted (incl. at full): cnt unchanged, both pointers increment.
REQ-021 cnt +1 on write-only accept, -1 on read-only accept; never exceeds DEPTH nor goes below 0.
REQ-022 Pointers wrap from DEPTH-1 to 0 with no extra cycle.
REQ-023 fifo_empty = (cnt==0); fifo_full = (cnt==DEPTH); fifo_cnt = cnt; all same cycle as cnt.
REQ-024 fifo_almost_full = (cnt>=AF_LEVEL); fifo_almost_empty = (cnt<=AE_LEVEL).

Reset
REQ-025 While !rst_ at a clk edge: rd_ptr=0, wr_ptr=0, cnt=0, fifo_data_out=0, overflow/underflow=0; requests that cycle ignored.
REQ-026 Hence after reset: fifo_empty=1, fifo_full=0, fifo_almost_empty=1, fifo_almost_full=0, fifo_cnt=0.
REQ-027 Reset mid-operation discards all contents; memory array itself not cleared.

Configuration
REQ-028 Macro FIFO_ERR_FLAGS_EN defined: fifo_overflow sets on a rejected write (write on full without read), fifo_underflow sets on read on empty; both stay set until reset.
REQ-029 Macro undefined: fifo_overflow and fifo_underflow tied to 0; no flag registers.

Structure
REQ-030 Package param_fifo_pkg SHALL hold default WIDTH/DEPTH constants and a cnt width helper function.
REQ-031 Storage SHALL be a sub-module param_fifo_mem (synchronous write, combinational read address, DEPTH x WIDTH); control stays in param_fifo.

Verification
REQ-032 Reset with fifo_write=1 asserted -> after release cnt=0, fifo_empty=1, fifo_full=0, pointers 0.
REQ-033 DEPTH=8: write 8 words 0x01..0x08 -> fifo_full=1 at cnt=8, almost_full=1 from cnt=6; 9th write 0xFF -> wr_ptr unchanged, overflow=1 (with macro).
REQ-034 Full FIFO, write 0xAA and read same cycle -> cnt stays 8, fifo_data_out=0x01 next cycle, wr_ptr wraps to 1.
REQ-035 Empty FIFO, read with write 0x55 same cycle -> rd_ptr unchanged, cnt=1, underflow=1 (with macro), next read returns 0x55.
REQ-036 Stream 20 writes/reads interleaved -> data out in order, pointers wrap twice, fifo_cnt always equals writes minus reads.
REQ-037 Assert rst_=0 with cnt=5 -> next cycle cnt=0, fifo_empty=1, error flags cleared.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
// Default word width/depth and the occupancy-counter width function live here.
package param_fifo_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 8;

  // Occupancy must represent 0..depth inclusive, hence one bit beyond the pointer width.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// DEPTH x WIDTH storage array for param_fifo: synchronous write port,
// combinational read port. Contents are not reset.
module param_fifo_mem
  import param_fifo_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Depth = DefDepth,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// Single-clock parameterised FIFO with registered read data and threshold flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   fifo_write,
  input  logic                   fifo_read,
  input  logic [WIDTH-1:0]       fifo_data_in,
  output logic [WIDTH-1:0]       fifo_data_out,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   fifo_almost_full,
  output logic                   fifo_almost_empty,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   fifo_overflow,
  output logic                   fifo_underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [PtrW-1:0]  rd_ptr, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr, wr_ptr_d;
  logic [CntW-1:0]  cnt, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             wr_acc, rd_acc;

  // A write is still accepted at full when a read frees the slot in the same cycle.
  assign wr_acc = fifo_write && (!fifo_full || fifo_read);
  assign rd_acc = fifo_read && !fifo_empty;

  always_comb begin
    rd_ptr_d   = rd_ptr;
    wr_ptr_d   = wr_ptr;
    cnt_d      = cnt;
    data_out_d = data_out_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr + PtrW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr + PtrW'(1);
      data_out_d = mem_rdata;
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt + CntW'(1);
      2'b01:   cnt_d = cnt - CntW'(1);
      default: cnt_d = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      data_out_q <= '0;
    end else begin
      rd_ptr     <= rd_ptr_d;
      wr_ptr     <= wr_ptr_d;
      cnt        <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Writes presented during reset must not disturb the array.
  param_fifo_mem #(
    .Width (WIDTH),
    .Depth (DEPTH),
    .AddrW (PtrW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc && rst_),
    .waddr_i (wr_ptr),
    .wdata_i (fifo_data_in),
    .raddr_i (rd_ptr),
    .rdata_o (mem_rdata)
  );

  assign fifo_data_out     = data_out_q;
  assign fifo_cnt          = cnt;
  assign fifo_empty        = (cnt == '0);
  assign fifo_full         = (cnt == CntW'(DEPTH));
  assign fifo_almost_full  = (cnt >= CntW'(AF_LEVEL));
  assign fifo_almost_empty = (cnt <= CntW'(AE_LEVEL));

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (fifo_write && fifo_full && !fifo_read) begin
        overflow_q <= 1'b1;
      end
      if (fifo_read && fifo_empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign fifo_overflow  = overflow_q;
  assign fifo_underflow = underflow_q;
`else
  assign fifo_overflow  = 1'b0;
  assign fifo_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo (DEPTH=8, WIDTH=8).
// Error-flag expectations follow whether FIFO_ERR_FLAGS_EN is defined.
module tb_param_fifo;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk;
  logic       rst_;
  logic       fifo_write;
  logic       fifo_read;
  logic [7:0] fifo_data_in;
  logic [7:0] fifo_data_out;
  logic       fifo_full, fifo_empty;
  logic       fifo_almost_full, fifo_almost_empty;
  logic [3:0] fifo_cnt;
  logic       fifo_overflow, fifo_underflow;

  int n_checks;
  int n_errors;

  param_fifo #(
    .WIDTH    (8),
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk               (clk),
    .rst_              (rst_),
    .fifo_write        (fifo_write),
    .fifo_read         (fifo_read),
    .fifo_data_in      (fifo_data_in),
    .fifo_data_out     (fifo_data_out),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_cnt          (fifo_cnt),
    .fifo_overflow     (fifo_overflow),
    .fifo_underflow    (fifo_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    fifo_write   = w;
    fifo_read    = r;
    fifo_data_in = d;
  endtask

  logic [7:0] model_q[$];
  logic [7:0] exp_dout;
  int         writes, reads, mcnt;
  bit         w, r, wa, ra;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_ = 1'b0;
    drive(1'b1, 1'b0, 8'h77);
    cycle();
    cycle();
    check_val("rst_rd_ptr", 32'(dut.rd_ptr), 32'd0);
    check_val("rst_wr_ptr", 32'(dut.wr_ptr), 32'd0);
    check_val("rst_cnt", 32'(dut.cnt), 32'd0);
    check_val("rst_empty", 32'(fifo_empty), 32'd1);
    check_val("rst_full", 32'(fifo_full), 32'd0);
    check_val("rst_ae", 32'(fifo_almost_empty), 32'd1);
    check_val("rst_af", 32'(fifo_almost_full), 32'd0);
    check_val("rst_dout", 32'(fifo_data_out), 32'd0);
    check_val("rst_ovf", 32'(fifo_overflow), 32'd0);
    check_val("rst_unf", 32'(fifo_underflow), 32'd0);

    rst_ = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    cycle();
    check_val("rel_cnt", 32'(fifo_cnt), 32'd0);
    check_val("rel_empty", 32'(fifo_empty), 32'd1);

    // Fill to full with 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      cycle();
      check_val("fill_cnt", 32'(fifo_cnt), 32'(i));
      check_val("fill_af", 32'(fifo_almost_full), 32'(i >= 6));
      check_val("fill_ae", 32'(fifo_almost_empty), 32'(i <= 2));
      check_val("fill_full", 32'(fifo_full), 32'(i == 8));
      check_val("fill_empty", 32'(fifo_empty), 32'd0);
    end
    check_val("fill_wr_wrap", 32'(dut.wr_ptr), 32'd0);

    drive(1'b1, 1'b0, 8'hFF);
    cycle();
    check_val("ovf_wr_ptr", 32'(dut.wr_ptr), 32'd0);
    check_val("ovf_cnt", 32'(fifo_cnt), 32'd8);
    check_val("ovf_flag", 32'(fifo_overflow), 32'(ErrEn));
    check_val("ovf_unf", 32'(fifo_underflow), 32'd0);

    // Simultaneous read and write at full.
    drive(1'b1, 1'b1, 8'hAA);
    cycle();
    check_val("rw_full_cnt", 32'(fifo_cnt), 32'd8);
    check_val("rw_full_dout", 32'(fifo_data_out), 32'h01);
    check_val("rw_full_wr_ptr", 32'(dut.wr_ptr), 32'd1);
    check_val("rw_full_rd_ptr", 32'(dut.rd_ptr), 32'd1);

    // Drain: 0x02..0x08 then 0xAA; the rejected 0xFF must not appear.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      cycle();
      check_val("drain_dout", 32'(fifo_data_out), (i < 7) ? 32'(i + 2) : 32'hAA);
      check_val("drain_cnt", 32'(fifo_cnt), 32'(7 - i));
    end
    check_val("drain_empty", 32'(fifo_empty), 32'd1);
    check_val("drain_rd_ptr", 32'(dut.rd_ptr), 32'd1);

    // Read on empty with a concurrent write.
    drive(1'b1, 1'b1, 8'h55);
    cycle();
    check_val("unf_rd_ptr", 32'(dut.rd_ptr), 32'd1);
    check_val("unf_cnt", 32'(fifo_cnt), 32'd1);
    check_val("unf_dout_hold", 32'(fifo_data_out), 32'hAA);
    check_val("unf_flag", 32'(fifo_underflow), 32'(ErrEn));
    drive(1'b0, 1'b1, 8'h00);
    cycle();
    check_val("unf_next_dout", 32'(fifo_data_out), 32'h55);
    check_val("unf_next_cnt", 32'(fifo_cnt), 32'd0);

    // Interleaved stream of 20 writes; pointers start at 2 and wrap twice.
    writes   = 0;
    reads    = 0;
    mcnt     = 0;
    exp_dout = 8'h55;
    for (int k = 0; k < 60 && !(writes == 20 && reads == 20); k++) begin
      w  = (writes < 20);
      r  = (k % 3 != 0);
      wa = w && (mcnt < 8 || r);
      ra = r && (mcnt > 0);
      drive(w, r, 8'(8'h10 + writes));
      if (ra) exp_dout = model_q.pop_front();
      if (wa) begin
        model_q.push_back(8'(8'h10 + writes));
        writes++;
      end
      if (ra) reads++;
      mcnt = writes - reads;
      cycle();
      check_val("strm_dout", 32'(fifo_data_out), 32'(exp_dout));
      check_val("strm_cnt", 32'(fifo_cnt), 32'(mcnt));
    end
    drive(1'b0, 1'b0, 8'h00);
    check_val("strm_reads", 32'(reads), 32'd20);
    check_val("strm_wr_ptr", 32'(dut.wr_ptr), 32'd6);
    check_val("strm_rd_ptr", 32'(dut.rd_ptr), 32'd6);

    // Reset mid-operation with five entries held.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'(8'h30 + i));
      cycle();
    end
    drive(1'b0, 1'b0, 8'h00);
    check_val("pre_rst_cnt", 32'(fifo_cnt), 32'd5);
    check_val("pre_rst_ovf", 32'(fifo_overflow), 32'(ErrEn));
    rst_ = 1'b0;
    cycle();
    check_val("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
    check_val("mid_rst_empty", 32'(fifo_empty), 32'd1);
    check_val("mid_rst_ovf", 32'(fifo_overflow), 32'd0);
    check_val("mid_rst_unf", 32'(fifo_underflow), 32'd0);
    check_val("mid_rst_dout", 32'(fifo_data_out), 32'd0);
    check_val("mid_rst_wr_ptr", 32'(dut.wr_ptr), 32'd0);
    rst_ = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
    cycle();
    check_val("post_rst_dout", 32'(fifo_data_out), 32'd0);
    check_val("post_rst_rd_ptr", 32'(dut.rd_ptr), 32'd0);
    check_val("post_rst_cnt", 32'(fifo_cnt), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
